// File: rtl/ref_cmp_sched_if.sv
// Word-stream interface between vec_cat, the batch sequencer and the compare array.
// The stream source drives the i_* signals and the sequencer drives the o_* signals.
interface ref_cmp_sched_if #(
  parameter int REF_VECTOR_NO = 8,
  parameter int SUBVEC_NO     = 2,
  parameter int CNT_WIDTH     = 16
);
  localparam int RW = (REF_VECTOR_NO > 1) ? $clog2(REF_VECTOR_NO) : 1;
  localparam int SW = (SUBVEC_NO > 1) ? $clog2(SUBVEC_NO) : 1;

  logic                 i_Start;
  logic                 i_Valid;
  logic                 i_Last;
  logic                 o_Ready;
  logic                 o_RefWrEn;
  logic [RW-1:0]        o_RefSlot;
  logic [SW-1:0]        o_SubIdx;
  logic                 o_CmpValid;
  logic [CNT_WIDTH-1:0] o_CmpCount;
  logic                 o_Done;
  logic                 o_Err;
  logic [2:0]           o_State;

  modport master (
    output i_Start, i_Valid, i_Last,
    input  o_Ready, o_RefWrEn, o_RefSlot, o_SubIdx, o_CmpValid,
    input  o_CmpCount, o_Done, o_Err, o_State
  );

  modport slave (
    input  i_Start, i_Valid, i_Last,
    output o_Ready, o_RefWrEn, o_RefSlot, o_SubIdx, o_CmpValid,
    output o_CmpCount, o_Done, o_Err, o_State
  );
endinterface

// File: rtl/ref_cmp_sched.sv
// Batch sequencer: loads REF_VECTOR_NO reference vectors, tags the remaining words as
// compare words up to the last one, drains the compare pipeline, then pulses o_Done.
module ref_cmp_sched #(
  parameter int REF_VECTOR_NO = 8,
  parameter int SUBVEC_NO     = 2,
  parameter int PIPE_DEPTH    = 6,
  parameter int CNT_WIDTH     = 16
) (
  input  logic            clk,
  input  logic            rst,
  ref_cmp_sched_if.slave  bus
);
  localparam int RW = (REF_VECTOR_NO > 1) ? $clog2(REF_VECTOR_NO) : 1;
  localparam int SW = (SUBVEC_NO > 1) ? $clog2(SUBVEC_NO) : 1;
  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CMP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state,      w_state_nxt;
  logic [SW-1:0]        r_sub_cnt,    w_sub_cnt_nxt;
  logic [RW-1:0]        r_ref_cnt,    w_ref_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_cmp_cnt,    w_cmp_cnt_nxt;
  logic [DW-1:0]        r_drain_cnt,  w_drain_cnt_nxt;
  logic                 r_err,        w_err_nxt;
  logic                 r_ref_wr_en,  w_ref_wr_en_nxt;
  logic [RW-1:0]        r_ref_slot,   w_ref_slot_nxt;
  logic [SW-1:0]        r_sub_idx,    w_sub_idx_nxt;
  logic                 r_cmp_valid,  w_cmp_valid_nxt;

  logic w_ready;
  logic w_accept;
  logic w_sub_wrap;
  logic w_ref_final;
  logic w_cnt_full;

  assign w_ready     = (r_state == S_LOAD) || (r_state == S_CMP);
  assign w_accept    = bus.i_Valid & w_ready;
  assign w_sub_wrap  = (r_sub_cnt == SW'(SUBVEC_NO - 1));
  assign w_ref_final = (r_ref_cnt == RW'(REF_VECTOR_NO - 1));
  assign w_cnt_full  = &r_cmp_cnt;

  // NOTE: every next-state value gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_sub_cnt_nxt   = r_sub_cnt;
    w_ref_cnt_nxt   = r_ref_cnt;
    w_cmp_cnt_nxt   = r_cmp_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_err_nxt       = r_err;
    w_ref_wr_en_nxt = 1'b0;
    w_ref_slot_nxt  = r_ref_slot;
    w_sub_idx_nxt   = r_sub_idx;
    w_cmp_valid_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.i_Start) begin
          w_sub_cnt_nxt = '0;
          w_ref_cnt_nxt = '0;
          w_cmp_cnt_nxt = '0;
          w_err_nxt     = 1'b0;
          w_state_nxt   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_ref_wr_en_nxt = 1'b1;
          w_ref_slot_nxt  = r_ref_cnt;
          w_sub_idx_nxt   = r_sub_cnt;
          // An early last still writes its word but leaves the reference set incomplete.
          if (bus.i_Last) begin
            w_err_nxt       = 1'b1;
            w_drain_cnt_nxt = DW'(PIPE_DEPTH - 1);
            w_state_nxt     = S_DRAIN;
          end else if (w_sub_wrap) begin
            w_sub_cnt_nxt = '0;
            if (w_ref_final) begin
              w_ref_cnt_nxt = '0;
              w_state_nxt   = S_CMP;
            end else begin
              w_ref_cnt_nxt = r_ref_cnt + RW'(1);
            end
          end else begin
            w_sub_cnt_nxt = r_sub_cnt + SW'(1);
          end
        end
      end
      S_CMP: begin
        if (w_accept) begin
          w_cmp_valid_nxt = 1'b1;
          w_sub_idx_nxt   = r_sub_cnt;
          if (w_sub_wrap) begin
            w_sub_cnt_nxt = '0;
            if (!w_cnt_full) w_cmp_cnt_nxt = r_cmp_cnt + CNT_WIDTH'(1);
          end else begin
            w_sub_cnt_nxt = r_sub_cnt + SW'(1);
          end
          if (bus.i_Last) begin
            w_drain_cnt_nxt = DW'(PIPE_DEPTH - 1);
            w_state_nxt     = S_DRAIN;
            if (!w_sub_wrap) w_err_nxt = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) w_state_nxt = S_DONE;
        else                   w_drain_cnt_nxt = r_drain_cnt - DW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sub_cnt   <= '0;
      r_ref_cnt   <= '0;
      r_cmp_cnt   <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
      r_ref_wr_en <= 1'b0;
      r_ref_slot  <= '0;
      r_sub_idx   <= '0;
      r_cmp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sub_cnt   <= w_sub_cnt_nxt;
      r_ref_cnt   <= w_ref_cnt_nxt;
      r_cmp_cnt   <= w_cmp_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_err       <= w_err_nxt;
      r_ref_wr_en <= w_ref_wr_en_nxt;
      r_ref_slot  <= w_ref_slot_nxt;
      r_sub_idx   <= w_sub_idx_nxt;
      r_cmp_valid <= w_cmp_valid_nxt;
    end
  end

  assign bus.o_Ready    = w_ready;
  assign bus.o_RefWrEn  = r_ref_wr_en;
  assign bus.o_RefSlot  = r_ref_slot;
  assign bus.o_SubIdx   = r_sub_idx;
  assign bus.o_CmpValid = r_cmp_valid;
  assign bus.o_CmpCount = r_cmp_cnt;
  assign bus.o_Done     = (r_state == S_DONE);
  assign bus.o_Err      = r_err;
  assign bus.o_State    = r_state;
endmodule

// File: tb/tb_ref_cmp_sched.sv
// Directed bench for ref_cmp_sched: vector tables for the word streams plus hand-written
// sequences for drain timing, reset abort and counter saturation.
module tb_ref_cmp_sched;
  localparam int PIPE_DEPTH = 6;
  localparam int REF_WORDS  = 16;

  logic clk;
  logic rst;

  ref_cmp_sched_if #(.REF_VECTOR_NO(8), .SUBVEC_NO(2), .CNT_WIDTH(16)) bus ();
  ref_cmp_sched_if #(.REF_VECTOR_NO(8), .SUBVEC_NO(2), .CNT_WIDTH(4))  bus6 ();

  ref_cmp_sched #(.REF_VECTOR_NO(8), .SUBVEC_NO(2), .PIPE_DEPTH(PIPE_DEPTH), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ref_cmp_sched #(.REF_VECTOR_NO(8), .SUBVEC_NO(2), .PIPE_DEPTH(PIPE_DEPTH), .CNT_WIDTH(4)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    bit last;
    bit ref_wr;
    int slot;
    int sub;
    bit cmp;
    int state;
  } vec_t;

  vec_t tbl[$];
  int   n_tests;
  int   n_fail;
  int   p_slot;
  int   p_sub;
  int   p_state;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected values: ref word w -> slot w/2, sub w%2; compare word j -> sub j%2.
  task automatic build(input int n_ref, input int n_cmp, input int gap, input bit with_last);
    int   total;
    vec_t v;
    total = n_ref + n_cmp;
    for (int w = 0; w < total; w++) begin
      bit is_last;
      for (int g = 0; g < gap; g++) begin
        v = '{valid: 1'b0, last: 1'b0, ref_wr: 1'b0, slot: p_slot, sub: p_sub, cmp: 1'b0, state: p_state};
        tbl.push_back(v);
      end
      is_last = with_last && (w == total - 1);
      if (w < n_ref) begin
        v = '{valid: 1'b1, last: is_last, ref_wr: 1'b1, slot: w / 2, sub: w % 2, cmp: 1'b0,
              state: is_last ? 3 : ((w == REF_WORDS - 1) ? 2 : 1)};
      end else begin
        v = '{valid: 1'b1, last: is_last, ref_wr: 1'b0, slot: p_slot, sub: (w - n_ref) % 2,
              cmp: 1'b1, state: is_last ? 3 : 2};
      end
      tbl.push_back(v);
      p_slot  = v.slot;
      p_sub   = v.sub;
      p_state = v.state;
    end
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      bus.i_Valid = tbl[i].valid;
      bus.i_Last  = tbl[i].last;
      tick();
      check($sformatf("%s[%0d].ref_wr", tag, i), int'(bus.o_RefWrEn),  int'(tbl[i].ref_wr));
      check($sformatf("%s[%0d].cmp",    tag, i), int'(bus.o_CmpValid), int'(tbl[i].cmp));
      check($sformatf("%s[%0d].slot",   tag, i), int'(bus.o_RefSlot),  tbl[i].slot);
      check($sformatf("%s[%0d].sub",    tag, i), int'(bus.o_SubIdx),   tbl[i].sub);
      check($sformatf("%s[%0d].state",  tag, i), int'(bus.o_State),    tbl[i].state);
    end
    bus.i_Valid = 1'b0;
    bus.i_Last  = 1'b0;
    tbl.delete();
  endtask

  task automatic start_batch(input string tag);
    bus.i_Start = 1'b1;
    tick();
    bus.i_Start = 1'b0;
    check({tag, ".start_state"}, int'(bus.o_State),    1);
    check({tag, ".start_ready"}, int'(bus.o_Ready),    1);
    check({tag, ".start_count"}, int'(bus.o_CmpCount), 0);
    check({tag, ".start_err"},   int'(bus.o_Err),      0);
    p_state = 1;
  endtask

  // Entered one sample after the last word's edge, which already showed DRAIN once.
  task automatic drain_done(input string tag, input int exp_cnt, input int exp_err);
    check({tag, ".drain0_ready"}, int'(bus.o_Ready), 0);
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      tick();
      check($sformatf("%s.drain%0d_state", tag, k), int'(bus.o_State), 3);
      check($sformatf("%s.drain%0d_ready", tag, k), int'(bus.o_Ready), 0);
      check($sformatf("%s.drain%0d_done",  tag, k), int'(bus.o_Done),  0);
    end
    tick();
    check({tag, ".done_state"}, int'(bus.o_State), 4);
    check({tag, ".done_pulse"}, int'(bus.o_Done),  1);
    tick();
    check({tag, ".idle_state"}, int'(bus.o_State),    0);
    check({tag, ".idle_done"},  int'(bus.o_Done),     0);
    check({tag, ".count"},      int'(bus.o_CmpCount), exp_cnt);
    check({tag, ".err"},        int'(bus.o_Err),      exp_err);
    p_state = 0;
  endtask

  initial begin
    int  budget;
    bit  seen_done;
    n_tests = 0;
    n_fail  = 0;
    p_slot  = 0;
    p_sub   = 0;
    p_state = 0;
    rst          = 1'b1;
    bus.i_Start  = 1'b0;
    bus.i_Valid  = 1'b0;
    bus.i_Last   = 1'b0;
    bus6.i_Start = 1'b0;
    bus6.i_Valid = 1'b0;
    bus6.i_Last  = 1'b0;

    #12;
    check("rst.state",   int'(bus.o_State),    0);
    check("rst.ready",   int'(bus.o_Ready),    0);
    check("rst.ref_wr",  int'(bus.o_RefWrEn),  0);
    check("rst.cmp",     int'(bus.o_CmpValid), 0);
    check("rst.count",   int'(bus.o_CmpCount), 0);
    check("rst.done",    int'(bus.o_Done),     0);
    check("rst.err",     int'(bus.o_Err),      0);
    tick();
    rst = 1'b0;
    tick();
    check("idle.state", int'(bus.o_State), 0);

    // Test 1: contiguous batch, 8 reference vectors then 3 compare vectors.
    start_batch("t1");
    build(16, 6, 0, 1'b1);
    run_table("t1");
    drain_done("t1", 3, 0);

    // Test 2: same batch at 1-of-3 valid duty.
    start_batch("t2");
    build(16, 6, 2, 1'b1);
    run_table("t2");
    drain_done("t2", 3, 0);

    // Test 3: last on the 5th reference word.
    start_batch("t3");
    build(5, 0, 0, 1'b1);
    run_table("t3");
    check("t3.err_now", int'(bus.o_Err), 1);
    drain_done("t3", 0, 1);

    // Test 4: last on the 5th compare word (partial vector).
    start_batch("t4");
    build(16, 5, 0, 1'b1);
    run_table("t4");
    drain_done("t4", 2, 1);
    start_batch("t4b");

    // Test 5: i_Start ignored mid-CMP, then asynchronous reset aborts the batch.
    build(16, 2, 0, 1'b0);
    run_table("t5");
    bus.i_Start = 1'b1;
    tick();
    tick();
    bus.i_Start = 1'b0;
    check("t5.start_ignored_state", int'(bus.o_State),    2);
    check("t5.start_ignored_count", int'(bus.o_CmpCount), 1);
    check("t5.start_ignored_ready", int'(bus.o_Ready),    1);
    #2;
    rst = 1'b1;
    #1;
    check("t5.async_state", int'(bus.o_State),    0);
    check("t5.async_ready", int'(bus.o_Ready),    0);
    check("t5.async_slot",  int'(bus.o_RefSlot),  0);
    check("t5.async_sub",   int'(bus.o_SubIdx),   0);
    check("t5.async_count", int'(bus.o_CmpCount), 0);
    check("t5.async_err",   int'(bus.o_Err),      0);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t5.post_done%0d", k),  int'(bus.o_Done),  0);
      check($sformatf("t5.post_state%0d", k), int'(bus.o_State), 0);
    end

    // Test 6: 4-bit counter saturates over 20 compare vectors.
    bus6.i_Start = 1'b1;
    tick();
    bus6.i_Start = 1'b0;
    bus6.i_Valid = 1'b1;
    for (int w = 0; w < REF_WORDS; w++) tick();
    check("t6.in_cmp", int'(bus6.o_State), 2);
    for (int j = 0; j < 40; j++) begin
      bus6.i_Last = (j == 39);
      tick();
      if (j == 27) check("t6.count_14", int'(bus6.o_CmpCount), 14);
      if (j == 29) check("t6.count_15", int'(bus6.o_CmpCount), 15);
      if (j == 31) check("t6.count_sat", int'(bus6.o_CmpCount), 15);
    end
    bus6.i_Valid = 1'b0;
    bus6.i_Last  = 1'b0;
    seen_done = 1'b0;
    budget    = 0;
    while (!seen_done && budget < 20) begin
      tick();
      budget++;
      if (bus6.o_Done) seen_done = 1'b1;
    end
    check("t6.done_seen",  int'(seen_done), 1);
    check("t6.done_cycle", budget, PIPE_DEPTH);
    check("t6.count_end",  int'(bus6.o_CmpCount), 15);
    check("t6.err",        int'(bus6.o_Err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
